// File: rtl/fsm_input_conditioner.sv
// Push-button front end for the lab FSM: synchronises and debounces btn_in into a
// clean level w, with one-cycle rise/fall strobes and a wrapping press counter.
module fsm_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  output logic             w,
  output logic             w_rise,
  output logic             w_fall,
  output logic [CNT_W-1:0] press_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    LOW,
    WAIT_HIGH,
    HIGH,
    WAIT_LOW
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             s1, s2;
  logic             w_next, rise_next, fall_next;
  logic [CNT_W-1:0] count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state       <= LOW;
      cnt         <= '0;
      w           <= 1'b0;
      w_rise      <= 1'b0;
      w_fall      <= 1'b0;
      press_count <= '0;
    end else begin
      s1          <= btn_in;
      s2          <= s1;
      state       <= state_next;
      cnt         <= cnt_next;
      w           <= w_next;
      w_rise      <= rise_next;
      w_fall      <= fall_next;
      press_count <= count_next;
    end
  end

  // A new level is accepted only after s2 holds it for DEBOUNCE_CYCLES+1 edges;
  // any disagreement in a WAIT state drops straight back with no partial credit.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    w_next     = w;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    count_next = press_count;
    case (state)
      LOW: begin
        w_next = 1'b0;
        if (s2) begin
          state_next = WAIT_HIGH;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = '0;
        end
      end
      WAIT_HIGH: begin
        w_next = 1'b0;
        if (!s2) begin
          state_next = LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = HIGH;
          w_next     = 1'b1;
          rise_next  = 1'b1;
          count_next = press_count + CNT_W'(1);
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        w_next = 1'b1;
        if (!s2) begin
          state_next = WAIT_LOW;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        w_next = 1'b1;
        if (s2) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = LOW;
          w_next     = 1'b0;
          fall_next  = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = LOW;
        w_next     = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

endmodule
